breathing_pwm: RTL and testbench
================================

BREATHING_PWM -- requirements
Module: breathing_pwm

Interface
REQ-001 Parameter WIDTH, default 8: bit width of the brightness level and the PWM counter.
REQ-002 Parameter HOLD_STEPS, default 16: number of step events spent at full and at zero brightness.
REQ-003 Port i_clock  input  1: single system clock; all state changes occur on its rising edge.
REQ-004 Port i_reset_n  input  1: reset, asynchronous and active-low.
REQ-005 Port i_step_clock  input  1: slow square wave from the upstream clock divider; each rising edge is one step event.
REQ-006 Port i_enable  input  1: level-sensitive run enable.
REQ-007 Port o_pwm  output  1: registered PWM drive for the LED.
REQ-008 Port o_level  output  WIDTH: current ramp brightness level.
REQ-009 Port o_phase  output  3: current state encoding.

Function
REQ-010 The block SHALL pass i_step_clock through a two-flop synchronizer, then a third flop; a step pulse SHALL equal sync2 AND NOT sync3, and the step SHALL act on the next i_clock edge.
REQ-011 The block SHALL produce exactly one step pulse per rising edge of i_step_clock and none on falling edges.
REQ-012 State machine states and encodings: IDLE=0, RISE=1, HOLD_HIGH=2, FALL=3, HOLD_LOW=4.
REQ-013 IDLE: level held at 0; when i_enable=1, the next state SHALL be RISE.
REQ-014 RISE: each step SHALL increment the level by 1; a step at level 2^WIDTH-2 SHALL set the level to max and enter HOLD_HIGH.
REQ-015 HOLD_HIGH: a step SHALL increment the hold counter; the state SHALL exit to FALL on the HOLD_STEPS-th step and clear the counter.
REQ-016 FALL: each step SHALL decrement the level by 1; a step at level 1 SHALL set the level to 0 and enter HOLD_LOW.
REQ-017 HOLD_LOW: the state SHALL behave like HOLD_HIGH but exit to RISE.
REQ-018 If HOLD_STEPS=0, the hold states SHALL be skipped: the step reaching max SHALL enter FALL, and the step reaching 0 SHALL enter RISE.
REQ-019 The level SHALL never wrap: it is saturating within 0..2^WIDTH-1.
REQ-020 i_enable=0 in any state SHALL, on the next edge, force IDLE, level 0, and hold counter 0; this SHALL take priority over a simultaneous step.
REQ-021 PWM counter: WIDTH bits, free-running, incrementing every i_clock and wrapping from 2^WIDTH-1 to 0.
REQ-022 A shadow level SHALL load o_level only on the edge where the PWM counter wraps to 0, so a PWM period never mixes two levels.
REQ-023 o_pwm SHALL be registered as (pwm counter < shadow level): duty = shadow/2^WIDTH, and level 0 gives constant low.
REQ-024 o_pwm SHALL be 0 from the edge that enters IDLE; entering IDLE SHALL also clear the shadow level.

Reset
REQ-025 Asserting i_reset_n low SHALL immediately clear, without a clock edge, the following: state to IDLE, o_level, shadow, hold counter, PWM counter, and all synchronizer flops to 0, and o_pwm to 0.
REQ-026 Reset asserted mid-ramp SHALL discard all progress; after release, operation SHALL resume at REQ-013.
REQ-027 The first i_step_clock edge after reset SHALL be detected only if the input rises after release.

Structure
REQ-028 The state encodings (REQ-012) and the o_phase width SHALL live in a shared package, breathing_pwm_pkg, so status and debug logic decode them identically.
REQ-029 The synchronizer and edge detector SHALL be one sub-module, edge_sync_rise (ports i_clock, i_reset_n, i_async, o_pulse), reusable for buttons.
REQ-030 The hold counter SHALL be clog2(HOLD_STEPS+1) bits wide, minimum 1.

Verification (WIDTH=4, HOLD_STEPS=2 unless stated)
REQ-031 Enable=1 with 15 step edges -> o_level 1..15, o_phase 1 then 2 after the 15th step; 2 more steps -> phase 3.
REQ-032 From level 15, 15 steps then 2 steps -> level reaches 0 with phase 4, then phase 1; total period 34 steps.
REQ-033 Shadow level 5 -> o_pwm high exactly 5 of every 16 clocks, aligned to counter wrap; a level change mid-period does not take effect until the wrap.
REQ-034 i_enable dropped in the same cycle as a step pulse at level 9 -> next edge phase 0, level 0, o_pwm 0.
REQ-035 i_reset_n pulsed low asynchronously between clock edges at level 12 -> outputs 0 before the next edge; after release and enable, the ramp restarts from 0.
REQ-036 HOLD_STEPS=0 -> phase sequence 1,3,1 with no 2 or 4, and a period of 30 steps.

Source files
------------

// File: rtl/breathing_pwm_pkg.sv
// breathing_pwm_pkg: phase encodings and counter sizing shared by the breathing LED ramp and its debug decode
package breathing_pwm_pkg;
  localparam int PHASE_W = 3;
  typedef enum logic [PHASE_W-1:0] {
    IDLE      = 3'd0,
    RISE      = 3'd1,
    HOLD_HIGH = 3'd2,
    FALL      = 3'd3,
    HOLD_LOW  = 3'd4
  } phase_t;
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/edge_sync_rise.sv
// edge_sync_rise: two-flop synchronizer plus edge flop giving one pulse per rising edge of an async input
module edge_sync_rise (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_async,
  output logic o_pulse
);
  logic sync1, sync2, sync3, valid, armed;
  // armed waits for a genuine low sample, so an input already high at release is not seen as an edge
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      valid <= 1'b0;
      armed <= 1'b0;
    end else begin
      sync1 <= i_async;
      sync2 <= sync1;
      sync3 <= sync2;
      valid <= 1'b1;
      armed <= armed | (valid & ~sync1);
    end
  assign o_pulse = armed & sync2 & ~sync3;
endmodule

// File: rtl/breathing_pwm.sv
// breathing_pwm: step-driven triangular brightness ramp with hold plateaus and a glitch-free PWM output
module breathing_pwm
  import breathing_pwm_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int HOLD_STEPS = 16
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_step_clock,
  input  logic               i_enable,
  output logic               o_pwm,
  output logic [WIDTH-1:0]   o_level,
  output logic [PHASE_W-1:0] o_phase
);
  localparam int HW = cnt_width(HOLD_STEPS + 1);
  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS == 0 ? 0 : HOLD_STEPS - 1);
  localparam bit NO_HOLD = (HOLD_STEPS == 0);
  phase_t state;
  logic step;
  logic [HW-1:0] hold_cnt;
  logic [WIDTH-1:0] pwm_cnt, pwm_next, shadow, shadow_next;
  edge_sync_rise u_sync (
    .i_clock  (i_clock),
    .i_reset_n(i_reset_n),
    .i_async  (i_step_clock),
    .o_pulse  (step)
  );
  assign o_phase = state;
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) begin
      state    <= IDLE;
      o_level  <= '0;
      hold_cnt <= '0;
    end else if (!i_enable) begin
      state    <= IDLE;
      o_level  <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: state <= RISE;
        RISE:
          if (step) begin
            if (o_level >= MAX - WIDTH'(1)) begin
              o_level <= MAX;
              state   <= NO_HOLD ? FALL : HOLD_HIGH;
            end else
              o_level <= o_level + WIDTH'(1);
          end
        HOLD_HIGH:
          if (step) begin
            if (hold_cnt == HOLD_LAST) begin
              hold_cnt <= '0;
              state    <= FALL;
            end else
              hold_cnt <= hold_cnt + HW'(1);
          end
        FALL:
          if (step) begin
            if (o_level <= WIDTH'(1)) begin
              o_level <= '0;
              state   <= NO_HOLD ? RISE : HOLD_LOW;
            end else
              o_level <= o_level - WIDTH'(1);
          end
        HOLD_LOW:
          if (step) begin
            if (hold_cnt == HOLD_LAST) begin
              hold_cnt <= '0;
              state    <= RISE;
            end else
              hold_cnt <= hold_cnt + HW'(1);
          end
        default: state <= IDLE;
      endcase
    end
  // shadow only follows the ramp at the counter wrap so each PWM period uses a single level
  assign pwm_next    = pwm_cnt + WIDTH'(1);
  assign shadow_next = !i_enable ? '0 : (pwm_cnt == MAX ? o_level : shadow);
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) begin
      pwm_cnt <= '0;
      shadow  <= '0;
      o_pwm   <= 1'b0;
    end else begin
      pwm_cnt <= pwm_next;
      shadow  <= shadow_next;
      o_pwm   <= pwm_next < shadow_next;
    end
endmodule

// File: tb/tb_breathing_pwm.sv
// tb_breathing_pwm: randomized step timing checked against a closed-form triangle-wave model
module tb_breathing_pwm;
  localparam int W = 4;
  localparam int LMAX = 15;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic step_clk = 1'b0;
  logic en = 1'b0;
  logic pwm_a, pwm_b;
  logic [W-1:0] lvl_a, lvl_b;
  logic [2:0] ph_a, ph_b;
  int tests = 0;
  int fails = 0;
  int k = 0;
  always #5 clk = ~clk;
  breathing_pwm #(.WIDTH(W), .HOLD_STEPS(2)) dut_a (
    .i_clock(clk), .i_reset_n(rst_n), .i_step_clock(step_clk), .i_enable(en),
    .o_pwm(pwm_a), .o_level(lvl_a), .o_phase(ph_a)
  );
  breathing_pwm #(.WIDTH(W), .HOLD_STEPS(0)) dut_b (
    .i_clock(clk), .i_reset_n(rst_n), .i_step_clock(step_clk), .i_enable(en),
    .o_pwm(pwm_b), .o_level(lvl_b), .o_phase(ph_b)
  );
  function automatic void model(input int steps, input int h, output int lvl, output int ph);
    int per;
    int p;
    per = 2 * LMAX + 2 * h;
    p = steps % per;
    if (p < LMAX) begin lvl = p; ph = 1; end
    else if (p < LMAX + h) begin lvl = LMAX; ph = 2; end
    else if (p < 2 * LMAX + h) begin lvl = LMAX - (p - LMAX - h); ph = 3; end
    else begin lvl = 0; ph = 4; end
  endfunction
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_step();
    step_clk = 1'b1;
    tick($urandom_range(4, 7));
    step_clk = 1'b0;
    tick($urandom_range(4, 7));
    k++;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    step_clk = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    k = 0;
  endtask
  task automatic start();
    en = 1'b1;
    tick(2);
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b0;
    step_clk = 1'b0;
    tick(3);
    tests++;
    if ({lvl_a, ph_a, pwm_a, lvl_b, ph_b, pwm_b} !== '0) begin
      fails++;
      $display("FAIL reset_held: a lvl=%0d ph=%0d pwm=%b b lvl=%0d ph=%0d pwm=%b, want all 0", lvl_a, ph_a, pwm_a, lvl_b, ph_b, pwm_b);
    end
    rst_n = 1'b1;
    tick(4);
    tests++;
    if ({lvl_a, ph_a, pwm_a} !== '0) begin
      fails++;
      $display("FAIL reset_idle: lvl=%0d ph=%0d pwm=%b, want 0 0 0", lvl_a, ph_a, pwm_a);
    end
    en = 1'b1;
    tick(1);
    tests++;
    if (ph_a !== 3'd1 || lvl_a !== '0) begin
      fails++;
      $display("FAIL enable_to_rise: ph=%0d lvl=%0d, want 1 0", ph_a, lvl_a);
    end
    en = 1'b0;
    tick(2);
  endtask
  task automatic test_ramp();
    int el, ep, bad;
    bad = 0;
    do_reset();
    start();
    for (int i = 0; i < 70; i++) begin
      do_step();
      model(k, 2, el, ep);
      tests++;
      if (lvl_a !== W'(el) || ph_a !== 3'(ep)) begin
        fails++;
        $display("FAIL ramp_hold2 step %0d: lvl=%0d ph=%0d, want lvl=%0d ph=%0d", k, lvl_a, ph_a, el, ep);
      end
      model(k, 0, el, ep);
      tests++;
      if (lvl_b !== W'(el) || ph_b !== 3'(ep)) begin
        fails++;
        $display("FAIL ramp_hold0 step %0d: lvl=%0d ph=%0d, want lvl=%0d ph=%0d", k, lvl_b, ph_b, el, ep);
      end
      if (ph_b == 3'd2 || ph_b == 3'd4) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL hold0_phases: hold phases seen %0d times, want 0", bad);
    end
  endtask
  task automatic test_first_edge();
    rst_n = 1'b0;
    en = 1'b0;
    step_clk = 1'b1;
    tick(2);
    rst_n = 1'b1;
    en = 1'b1;
    tick(10);
    tests++;
    if (lvl_a !== '0 || ph_a !== 3'd1) begin
      fails++;
      $display("FAIL first_edge_high: lvl=%0d ph=%0d, want 0 1", lvl_a, ph_a);
    end
    step_clk = 1'b0;
    tick(5);
    step_clk = 1'b1;
    tick(5);
    tests++;
    if (lvl_a !== W'(1)) begin
      fails++;
      $display("FAIL first_edge_rise: lvl=%0d, want 1", lvl_a);
    end
    step_clk = 1'b0;
    tick(5);
  endtask
  task automatic test_pwm();
    logic s [64];
    logic prev;
    int found, highs, lv, mism;
    do_reset();
    start();
    repeat (5) do_step();
    tests++;
    if (lvl_a !== W'(5)) begin
      fails++;
      $display("FAIL pwm_level: lvl=%0d, want 5", lvl_a);
    end
    found = 0;
    prev = pwm_a;
    for (int i = 0; i < 80 && found == 0; i++) begin
      tick(1);
      if (pwm_a && !prev) found = 1;
      prev = pwm_a;
    end
    tests++;
    if (found == 0) begin
      fails++;
      $display("FAIL pwm_sync: no rising edge within 80 clocks, want one");
    end else begin
      s[0] = pwm_a;
      for (int i = 1; i < 64; i++) begin
        if (i == 20) step_clk = 1'b1;
        if (i == 30) step_clk = 1'b0;
        tick(1);
        s[i] = pwm_a;
      end
      for (int j = 0; j < 4; j++) begin
        lv = (j < 2) ? 5 : 6;
        highs = 0;
        mism = 0;
        for (int b = 0; b < 16; b++) begin
          if (s[16*j+b]) highs++;
          if (s[16*j+b] !== (b < lv)) mism++;
        end
        tests++;
        if (mism != 0) begin
          fails++;
          $display("FAIL pwm_period %0d: highs=%0d misplaced=%0d, want %0d highs leading the period", j, highs, mism, lv);
        end
      end
    end
    tick(4);
  endtask
  task automatic test_enable_drop();
    int el, ep;
    do_reset();
    start();
    repeat (9) do_step();
    model(k, 2, el, ep);
    tests++;
    if (lvl_a !== W'(el) || lvl_a !== W'(9)) begin
      fails++;
      $display("FAIL drop_setup: lvl=%0d, want 9", lvl_a);
    end
    step_clk = 1'b1;
    tick(2);
    tests++;
    if (lvl_a !== W'(9) || ph_a !== 3'd1) begin
      fails++;
      $display("FAIL drop_pre: lvl=%0d ph=%0d, want 9 1", lvl_a, ph_a);
    end
    en = 1'b0;
    tick(1);
    tests++;
    if (lvl_a !== '0 || ph_a !== 3'd0 || pwm_a !== 1'b0) begin
      fails++;
      $display("FAIL drop_priority: lvl=%0d ph=%0d pwm=%b, want 0 0 0", lvl_a, ph_a, pwm_a);
    end
    step_clk = 1'b0;
    tick(5);
  endtask
  task automatic test_async_reset();
    int el, ep;
    do_reset();
    start();
    repeat (12) do_step();
    tests++;
    if (lvl_a !== W'(12)) begin
      fails++;
      $display("FAIL areset_setup: lvl=%0d, want 12", lvl_a);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (lvl_a !== '0 || ph_a !== 3'd0 || pwm_a !== 1'b0) begin
      fails++;
      $display("FAIL areset_immediate: lvl=%0d ph=%0d pwm=%b, want 0 0 0", lvl_a, ph_a, pwm_a);
    end
    tick(2);
    rst_n = 1'b1;
    tick(2);
    k = 0;
    tests++;
    if (lvl_a !== '0 || ph_a !== 3'd1) begin
      fails++;
      $display("FAIL areset_restart: lvl=%0d ph=%0d, want 0 1", lvl_a, ph_a);
    end
    repeat (3) begin
      do_step();
      model(k, 2, el, ep);
      tests++;
      if (lvl_a !== W'(el) || ph_a !== 3'(ep)) begin
        fails++;
        $display("FAIL areset_ramp step %0d: lvl=%0d ph=%0d, want lvl=%0d ph=%0d", k, lvl_a, ph_a, el, ep);
      end
    end
  endtask
  initial begin
    test_reset();
    test_ramp();
    test_first_edge();
    test_pwm();
    test_enable_drop();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end
endmodule
